planar_filter_pair_gen: RTL

//  Pair source for planar_filter_normalized: streams every (home, neighbour) particle pair of one cell pair.

---
 rtl/planar_filter_pair_gen.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/planar_filter_pair_gen.sv
// planar_filter_pair_gen
//   Streams every (home, neighbour) particle pair of one cell pair to a
//   downstream planar filter. Home and neighbour positions are fetched from
//   two caches with 1-cycle read latency. Returned neighbour data is combined
//   with the latched home position and written into a 2-entry output FIFO.
//   The pair outputs are driven from the FIFO head. In same-cell mode each
//   unordered pair is emitted once and self-pairs are skipped.
//
// Ports
//   clk, rst             clock; synchronous active-low reset
//   start                run request, accepted only while idle
//   home_count, nb_count particle counts (0..2^ADDR_WIDTH), sampled at start
//   same_cell            emit only nb_idx > home_idx, sampled at start
//   home_rd_addr/data    home position cache port (data valid next cycle)
//   nb_rd_addr/en/data   neighbour position cache port (data valid next cycle)
//   pair_valid/ready     output handshake; a pair transfers when both are high
//   x1,y1,z1 / x2,y2,z2  home / neighbour position of the head pair
//   home_idx, nb_idx     particle indices of the head pair
//   busy                 run in progress (LOAD_HOME through DRAIN)
//   done                 1-cycle pulse at the end of a run
//   pair_count           pairs accepted in the current run
module planar_filter_pair_gen #(
  parameter int CELL_ID_WIDTH = 3,
  parameter int BODY_BITS     = 8,
  parameter int ADDR_WIDTH    = 7
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ADDR_WIDTH:0]                   home_count,
  input  logic [ADDR_WIDTH:0]                   nb_count,
  input  logic                                  same_cell,
  output logic [ADDR_WIDTH-1:0]                 home_rd_addr,
  input  logic [3*(CELL_ID_WIDTH+BODY_BITS)-1:0] home_rd_data,
  output logic [ADDR_WIDTH-1:0]                 nb_rd_addr,
  output logic                                  nb_rd_en,
  input  logic [3*(CELL_ID_WIDTH+BODY_BITS)-1:0] nb_rd_data,
  output logic                                  pair_valid,
  input  logic                                  pair_ready,
  output logic [CELL_ID_WIDTH+BODY_BITS-1:0]    x1,
  output logic [CELL_ID_WIDTH+BODY_BITS-1:0]    y1,
  output logic [CELL_ID_WIDTH+BODY_BITS-1:0]    z1,
  output logic [CELL_ID_WIDTH+BODY_BITS-1:0]    x2,
  output logic [CELL_ID_WIDTH+BODY_BITS-1:0]    y2,
  output logic [CELL_ID_WIDTH+BODY_BITS-1:0]    z2,
  output logic [ADDR_WIDTH-1:0]                 home_idx,
  output logic [ADDR_WIDTH-1:0]                 nb_idx,
  output logic                                  busy,
  output logic                                  done,
  output logic [2*ADDR_WIDTH:0]                 pair_count
);

  localparam int POS_W  = CELL_ID_WIDTH + BODY_BITS;
  localparam int DATA_W = 3 * POS_W;
  localparam int ENT_W  = 2 * DATA_W + 2 * ADDR_WIDTH;
  localparam int CNT_W  = ADDR_WIDTH + 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD_HOME = 3'd1;
  localparam logic [2:0] STREAM    = 3'd2;
  localparam logic [2:0] DRAIN     = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0]            state_r, state_nx_s;
  logic [ADDR_WIDTH-1:0] h_r, h_nx_s;
  logic [ADDR_WIDTH-1:0] n_r, n_nx_s;
  logic                  phase_r, phase_nx_s;
  logic                  latch_home_s;
  logic [CNT_W-1:0]      home_count_r, nb_count_r;
  logic                  same_cell_r;
  logic [DATA_W-1:0]     home_pos_r;

  // Neighbour read in flight plus the metadata that travels with it.
  logic                  inflight_r;
  logic [ADDR_WIDTH-1:0] pend_h_r, pend_n_r;

  // Two-entry output FIFO: {home_pos, nb_pos, home_idx, nb_idx} per entry.
  logic [ENT_W-1:0]      entry0_r, entry1_r, head_s;
  logic                  wr_ptr_r, rd_ptr_r;
  logic [1:0]            occ_r;
  logic [2:0]            room_sum_s;

  logic                  pop_s, issue_s, accept_s;
  logic [CNT_W-1:0]      n0_s;
  logic                  last_n_s, last_h_s, zero_req_s;
  logic                  done_r, busy_r;
  logic [2*ADDR_WIDTH:0] pair_count_r;

  assign pair_valid   = (occ_r != 2'd0);
  assign pop_s        = pair_valid && pair_ready;
  // Occupancy the FIFO will have once the in-flight read lands; at most one more read may go out.
  assign room_sum_s   = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign issue_s      = (state_r == STREAM) && (room_sum_s < 3'd2);
  assign accept_s     = (state_r == IDLE) && start;
  assign zero_req_s   = (home_count == {CNT_W{1'b0}}) || (nb_count == {CNT_W{1'b0}});
  assign n0_s         = same_cell_r ? ({1'b0, h_r} + CNT_W'(1)) : {CNT_W{1'b0}};
  assign last_n_s     = ({1'b0, n_r} == (nb_count_r - CNT_W'(1)));
  assign last_h_s     = ({1'b0, h_r} == (home_count_r - CNT_W'(1)));

  assign head_s       = rd_ptr_r ? entry1_r : entry0_r;
  assign x1           = head_s[ENT_W-1         -: POS_W];
  assign y1           = head_s[ENT_W-1-POS_W   -: POS_W];
  assign z1           = head_s[ENT_W-1-2*POS_W -: POS_W];
  assign x2           = head_s[ENT_W-1-3*POS_W -: POS_W];
  assign y2           = head_s[ENT_W-1-4*POS_W -: POS_W];
  assign z2           = head_s[ENT_W-1-5*POS_W -: POS_W];
  assign home_idx     = head_s[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign nb_idx       = head_s[ADDR_WIDTH-1:0];

  assign home_rd_addr = h_r;
  assign nb_rd_addr   = n_r;
  assign nb_rd_en     = issue_s;
  assign busy         = busy_r;
  assign done         = done_r;
  assign pair_count   = pair_count_r;

  // Next-state and index sequencing for the run FSM.
  always_comb begin
    state_nx_s   = state_r;
    h_nx_s       = h_r;
    n_nx_s       = n_r;
    phase_nx_s   = phase_r;
    latch_home_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          h_nx_s     = {ADDR_WIDTH{1'b0}};
          phase_nx_s = 1'b0;
          if (zero_req_s) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = LOAD_HOME;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD_HOME: begin
        // Phase 0 presents the address; phase 1 sees the cache data.
        if (!phase_r) begin
          phase_nx_s = 1'b1;
        end else begin
          phase_nx_s   = 1'b0;
          latch_home_s = 1'b1;
          if (n0_s >= nb_count_r) begin
            if (last_h_s) begin
              state_nx_s = DRAIN;
            end else begin
              h_nx_s = h_r + ADDR_WIDTH'(1);
            end
          end else begin
            n_nx_s     = n0_s[ADDR_WIDTH-1:0];
            state_nx_s = STREAM;
          end
        end
      end
      STREAM: begin
        if (issue_s) begin
          if (last_n_s) begin
            if (last_h_s) begin
              state_nx_s = DRAIN;
            end else begin
              h_nx_s     = h_r + ADDR_WIDTH'(1);
              phase_nx_s = 1'b0;
              state_nx_s = LOAD_HOME;
            end
          end else begin
            n_nx_s = n_r + ADDR_WIDTH'(1);
          end
        end else begin
          state_nx_s = STREAM;
        end
      end
      DRAIN: begin
        if (!inflight_r && (occ_r == 2'd0)) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Control registers, sampled run parameters and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      h_r          <= {ADDR_WIDTH{1'b0}};
      n_r          <= {ADDR_WIDTH{1'b0}};
      phase_r      <= 1'b0;
      home_count_r <= {CNT_W{1'b0}};
      nb_count_r   <= {CNT_W{1'b0}};
      same_cell_r  <= 1'b0;
      home_pos_r   <= {DATA_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pair_count_r <= {(2*ADDR_WIDTH+1){1'b0}};
    end else begin
      state_r <= state_nx_s;
      h_r     <= h_nx_s;
      n_r     <= n_nx_s;
      phase_r <= phase_nx_s;
      if (accept_s) begin
        home_count_r <= home_count;
        nb_count_r   <= nb_count;
        same_cell_r  <= same_cell;
      end
      if (latch_home_s) begin
        home_pos_r <= home_rd_data;
      end
      busy_r <= (state_nx_s == LOAD_HOME) || (state_nx_s == STREAM) || (state_nx_s == DRAIN);
      done_r <= (state_r == DONE);
      if (accept_s) begin
        pair_count_r <= {(2*ADDR_WIDTH+1){1'b0}};
      end else if (pop_s) begin
        pair_count_r <= pair_count_r + (2*ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Read-return pipeline and output FIFO. home_pos_r is safe to use at the
  // write because the next home latch is at least one cycle after the last return.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_r <= 1'b0;
      pend_h_r   <= {ADDR_WIDTH{1'b0}};
      pend_n_r   <= {ADDR_WIDTH{1'b0}};
      entry0_r   <= {ENT_W{1'b0}};
      entry1_r   <= {ENT_W{1'b0}};
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      occ_r      <= 2'd0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        pend_h_r <= h_r;
        pend_n_r <= n_r;
      end
      if (inflight_r) begin
        if (wr_ptr_r) begin
          entry1_r <= {home_pos_r, nb_rd_data, pend_h_r, pend_n_r};
        end else begin
          entry0_r <= {home_pos_r, nb_rd_data, pend_h_r, pend_n_r};
        end
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      occ_r <= occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

endmodule
